// File: rtl/quad_pkg.sv
// Shared types, constants and the Gray-phase step decoder for quad_decoder.
package quad_pkg;

    typedef logic [1:0] phase_t;               // {x, y}
    typedef enum logic {INIT, TRACK} fsm_t;

    localparam int MODE_X1     = 1;
    localparam int MODE_X2     = 2;
    localparam int MODE_X4     = 4;
    localparam int INIT_CYCLES = 3;

    // Classify a phase change: {legal, fwd}. Legal means exactly one bit flipped.
    // Forward order is 00 -> 10 -> 11 -> 01 -> 00.
    function automatic logic [1:0] decode_step(phase_t prv, phase_t nxt);
        phase_t fwd_next;
        phase_t diff;
        logic   legal;
        case (prv)
            2'b00:   fwd_next = 2'b10;
            2'b10:   fwd_next = 2'b11;
            2'b11:   fwd_next = 2'b01;
            default: fwd_next = 2'b00;
        endcase
        diff  = prv ^ nxt;
        legal = (diff == 2'b01) || (diff == 2'b10);
        return {legal, nxt == fwd_next};
    endfunction

endpackage

// File: rtl/quad_debounce.sv
// One encoder channel: 2-flop synchroniser followed by a stability filter.
module quad_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic bypass,   // load filt straight from the synchroniser
    output logic synced,
    output logic filt
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          meta;
    logic [CW-1:0] cnt;

    // Two-stage synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            synced <= 1'b0;
        end else begin
            meta   <= din;
            synced <= meta;
        end
    end

    // Accept a new level only after DB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (bypass) begin
            filt <= synced;
            cnt  <= '0;
        end else if (synced != filt) begin
            if (cnt == CNT_MAX) begin
                filt <= synced;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Registered quadrature decoder: debounced X/Y, Gray-phase tracking FSM,
// step/dir pulse, wrapping or saturating position, sticky error flag.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DB_CYCLES   = 4,
    parameter int DECODE_MODE = 4,
    parameter bit WRAP        = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enc_x,
    input  logic             enc_y,
    input  logic             clear,
    input  logic             err_clr,
    output logic [CNT_W-1:0] pos,
    output logic             step,
    output logic             dir,
    output logic             err
);

    fsm_t       state, state_nx;
    logic [1:0] init_cnt, init_nx;
    phase_t     synced, filt, phase;
    logic       bypass;
    logic       chg, legal, fwd, qual;
    logic [CNT_W-1:0] pos_nx;

    assign bypass = (state == INIT);

    quad_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_x (
        .clk(clk), .rst_n(rst_n), .din(enc_x), .bypass(bypass),
        .synced(synced[1]), .filt(filt[1])
    );

    quad_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_y (
        .clk(clk), .rst_n(rst_n), .din(enc_y), .bypass(bypass),
        .synced(synced[0]), .filt(filt[0])
    );

    // FSM state register and INIT duration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nx;
            init_cnt <= init_nx;
        end
    end

    // Next state: stay in INIT for INIT_CYCLES edges, then track forever.
    always_comb begin
        state_nx = state;
        init_nx  = init_cnt;
        case (state)
            INIT: begin
                if (init_cnt == 2'(INIT_CYCLES - 1)) state_nx = TRACK;
                else                                 init_nx  = init_cnt + 1'b1;
            end
            default: ;
        endcase
    end

    // Change detection, legality/direction and mode qualification.
    always_comb begin
        chg          = (state == TRACK) && (filt != phase);
        {legal, fwd} = decode_step(phase, filt);
        case (DECODE_MODE)
            MODE_X1: qual = legal && (((phase == 2'b00) && (filt == 2'b10)) ||
                                      ((phase == 2'b10) && (filt == 2'b00)));
            MODE_X2: qual = legal && (phase[1] != filt[1]);
            default: qual = legal;
        endcase
        if (fwd) pos_nx = (!WRAP && (pos == {CNT_W{1'b1}})) ? pos : pos + 1'b1;
        else     pos_nx = (!WRAP && (pos == '0))            ? pos : pos - 1'b1;
    end

    // Phase tracking and registered outputs. During INIT the phase loads the
    // same synchronised value the filter loads, so both agree on entry to TRACK
    // even when the pins sit away from 00 across reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 2'b00;
            pos   <= '0;
            step  <= 1'b0;
            dir   <= 1'b0;
            err   <= 1'b0;
        end else begin
            step <= 1'b0;
            if (err_clr) err <= 1'b0;           // a new illegal change below wins
            if (state == INIT) begin
                phase <= synced;
            end else if (chg) begin
                phase <= filt;
                if (!legal) begin
                    err <= 1'b1;
                end else if (qual) begin
                    step <= 1'b1;
                    dir  <= fwd;
                    pos  <= pos_nx;
                end
            end
            if (clear) pos <= '0;               // clear wins over a count
        end
    end

endmodule
